// File: rtl/keypad_reader_pkg.sv
// keypad_reader_pkg: scan FSM state encoding and key-index width helper.
package keypad_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_EVAL  = 2'd2;

    function automatic int key_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_debouncer.sv
// scan_debouncer: accepts a raw scan vector only after DEBOUNCE_SCANS identical scans.
module scan_debouncer #(
    parameter int NUM_KEYS       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_eval,
    input  logic [NUM_KEYS-1:0] i_scan,
    output logic [NUM_KEYS-1:0] o_keys,
    output logic [NUM_KEYS-1:0] o_rise
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] raw_q, raw_d, keys_q, keys_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        raw_d  = i_eval ? i_scan : raw_q;
        cnt_d  = !i_eval ? cnt_q :
                 (i_scan != raw_q) ? CW'(1) :
                 (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
        keys_d = (i_eval && cnt_d == CMAX) ? i_scan : keys_q;
        o_rise = keys_d & ~keys_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q  <= '0;
            cnt_q  <= '0;
            keys_q <= '0;
        end else begin
            raw_q  <= raw_d;
            cnt_q  <= cnt_d;
            keys_q <= keys_d;
        end
    end

    assign o_keys = keys_q;

endmodule

// File: rtl/keypad_reader.sv
// keypad_reader: scans a 74HC165-style key chain, debounces it and queues key-press events.
module keypad_reader
    import keypad_reader_pkg::*;
#(
    parameter int NUM_KEYS       = 16,
    parameter int CLK_DIV        = 4,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_sr_data,
    output logic                          o_sr_clk,
    output logic                          o_sr_load_n,
    output logic [key_w(NUM_KEYS)-1:0]    o_key_code,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NUM_KEYS-1:0]           o_keys
);

    localparam int KW = key_w(NUM_KEYS);
    localparam int DW = key_w(CLK_DIV);

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [KW-1:0]       bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [1:0]          sync_q, sync_d;
    logic [NUM_KEYS-1:0] shift_q, shift_d;
    logic                eval_q, eval_d;
    logic                sr_clk_q, sr_clk_d;
    logic                load_n_q, load_n_d;
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [KW-1:0]       code_q, code_d;
    logic [KW-1:0]       low;
    logic [NUM_KEYS-1:0] rise;
    logic                div_end, hs;

    always_comb begin
        sync_d  = {sync_q[0], i_sr_data};
        div_end = div_q == DW'(CLK_DIV - 1);
        div_d   = (state_q == ST_EVAL || div_end) ? '0 : div_q + DW'(1);
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_LOAD: begin
                if (div_end) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    phase_d = !phase_q;
                    if (!phase_q)
                        shift_d = (shift_q << 1) | NUM_KEYS'(sync_q[1]);
                    else if (bit_q == KW'(NUM_KEYS - 1))
                        state_d = ST_EVAL;
                    else
                        bit_d = bit_q + KW'(1);
                end
            end
            default: state_d = ST_LOAD;
        endcase
        eval_d   = state_d == ST_EVAL;
        sr_clk_d = state_d == ST_SHIFT && phase_d;
        load_n_d = state_d != ST_LOAD;
    end

    scan_debouncer #(
        .NUM_KEYS      (NUM_KEYS),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .i_eval(eval_q),
        .i_scan(shift_q),
        .o_keys(o_keys),
        .o_rise(rise)
    );

    // A presented code is held until accepted; a same-cycle re-press keeps its bit set.
    always_comb begin
        hs     = valid_q && i_ready;
        pend_d = (pend_q & ~(hs ? (NUM_KEYS'(1) << code_q) : '0)) | rise;
        low    = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (pend_d[i]) low = KW'(i);
        valid_d = (valid_q && !hs) ? 1'b1 : |pend_d;
        code_d  = (valid_q && !hs) ? code_q : low;
    end

    // Reset parks in a strobe-less EVAL so the first edge afterwards enters LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EVAL;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            sync_q   <= '0;
            shift_q  <= '0;
            eval_q   <= 1'b0;
            sr_clk_q <= 1'b0;
            load_n_q <= 1'b1;
            pend_q   <= '0;
            valid_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            sync_q   <= sync_d;
            shift_q  <= shift_d;
            eval_q   <= eval_d;
            sr_clk_q <= sr_clk_d;
            load_n_q <= load_n_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
        end
    end

    assign o_sr_clk    = sr_clk_q;
    assign o_sr_load_n = load_n_q;
    assign o_valid     = valid_q;
    assign o_key_code  = code_q;

endmodule

// File: tb/tb_keypad_reader.sv
// tb_keypad_reader: random and directed key patterns against a scan-level reference model.
module tb_keypad_reader;

    localparam int N    = 16;
    localparam int CD   = 4;
    localparam int DB   = 4;
    localparam int SCAN = CD * (2 * N + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_sr_data;
    logic          i_ready = 1'b0;
    logic          o_sr_clk, o_sr_load_n, o_valid;
    logic [3:0]    o_key_code;
    logic [N-1:0]  o_keys;

    logic [N-1:0]  phys = '0;
    logic [N-1:0]  snap = '0;
    int            idx = 0;

    int            checks = 0;
    int            failures = 0;

    int            cyc = 0, off = 0, s = 0, ev = 0;
    logic [N-1:0]  scans[$];
    logic [N-1:0]  m_keys = '0, m_pend = '0;
    logic          m_valid = 1'b0, hs = 1'b0, commit = 1'b0;
    int            m_code = 0;

    keypad_reader dut (
        .clk        (clk),
        .rst        (rst),
        .i_sr_data  (i_sr_data),
        .o_sr_clk   (o_sr_clk),
        .o_sr_load_n(o_sr_load_n),
        .o_key_code (o_key_code),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_keys     (o_keys)
    );

    always #5 clk = ~clk;

    // 74HC165 model: transparent load while load_n is low, shift on sr_clk rise.
    always @(posedge o_sr_load_n) begin
        snap = phys;
        idx  = 0;
    end
    always @(posedge o_sr_clk) idx++;
    always_comb i_sr_data = !o_sr_load_n ? phys[N-1] : (idx < N) ? snap[N-1-idx] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Reference model on the scan timeline: LOAD at offsets 0..CD-1, EVAL at SCAN-1.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            scans.delete();
            m_keys = '0;
            m_pend = '0;
            m_valid = 1'b0;
            m_code = 0;
            ev = 0;
        end else begin
            if (o_valid && i_ready) ev++;
            hs  = m_valid && i_ready;
            cyc++;
            off = (cyc - 1) % SCAN;
            if (off == CD) scans.push_back(phys);
            if (hs) m_pend[m_code] = 1'b0;
            if (off == 0 && cyc > 1) begin
                s = scans.size() - 1;
                commit = s >= DB - 1;
                for (int k = 1; k < DB; k++)
                    if (commit && scans[s-k] != scans[s]) commit = 1'b0;
                if (commit) begin
                    m_pend = m_pend | (scans[s] & ~m_keys);
                    m_keys = scans[s];
                end
            end
            if (!m_valid || hs) begin
                m_valid = m_pend != '0;
                m_code  = lowest(m_pend);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("load_n", 32'(o_sr_load_n), 32'(!(cyc > 0 && off < CD)));
            chk("sr_clk", 32'(o_sr_clk),
                32'(cyc > 0 && off >= CD && off < SCAN - 1 && ((off - CD) / CD) % 2 == 1));
            chk("keys", 32'(o_keys), 32'(m_keys));
            chk("valid", 32'(o_valid), 32'(m_valid));
            chk("code", 32'(o_key_code), 32'(m_code));
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_sr_clk"}, 32'(o_sr_clk), 0);
        chk({tag, "_load_n"}, 32'(o_sr_load_n), 1);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_code"}, 32'(o_key_code), 0);
        chk({tag, "_keys"}, 32'(o_keys), 0);
    endtask

    task automatic do_reset(input logic [N-1:0] p, input logic rdy);
        rst = 1'b1;
        phys = p;
        i_ready = rdy;
        repeat (2) @(negedge clk);
        #1 reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int waited;
        repeat (2) @(negedge clk);
        #1 reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        repeat (3 * SCAN) @(negedge clk);
        chk("zero_events", 32'(ev), 0);

        do_reset(N'(1) << 5, 1'b1);
        repeat (7 * SCAN) @(negedge clk);
        chk("key5_keys", 32'(o_keys), 32'h0020);
        chk("key5_events", 32'(ev), 1);

        do_reset(N'(1) << 9, 1'b1);
        repeat (6) begin
            repeat (SCAN) @(negedge clk);
            phys[9] = !phys[9];
        end
        repeat (2 * SCAN - 10) @(negedge clk);
        chk("key9_keys", 32'(o_keys), 0);
        chk("key9_events", 32'(ev), 0);

        do_reset((N'(1) << 3) | (N'(1) << 12), 1'b0);
        repeat (5 * SCAN + 500) @(negedge clk);
        chk("k3_12_hold_valid", 32'(o_valid), 1);
        chk("k3_12_hold_code", 32'(o_key_code), 3);
        i_ready = 1'b1;
        @(negedge clk);
        chk("k3_12_second", 32'(o_key_code), 12);
        @(negedge clk);
        chk("k3_12_done", 32'(o_valid), 0);
        chk("k3_12_events", 32'(ev), 2);

        do_reset(N'(1) << 7, 1'b0);
        repeat (5 * SCAN) @(negedge clk);
        phys = '0;
        repeat (5 * SCAN) @(negedge clk);
        chk("k7_released", 32'(o_keys), 0);
        i_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("k7_events", 32'(ev), 1);

        do_reset('0, 1'b0);
        for (int c = 0; c < 40 * SCAN; c++) begin
            @(negedge clk);
            i_ready = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 299) == 0) begin
                phys = $urandom_range(0, 2) == 0 ? '0 : N'(1) << $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 1) phys[$urandom_range(0, N - 1)] = 1'b1;
            end
        end

        phys = N'(1) << 2;
        i_ready = 1'b1;
        repeat (6 * SCAN) @(negedge clk);
        waited = 0;
        while (off != CD + 6 * 2 * CD + 2 && waited < 2 * SCAN) begin
            @(negedge clk);
            waited++;
        end
        chk("bit6_wait", 32'(waited < 2 * SCAN), 1);
        #2 rst = 1'b1;
        #1 reset_vals("mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * SCAN) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
